// File: rtl/ahbl_bus_mux_nm_pkg.sv
`default_nettype none
// ============================================================================
// Package : ahbl_bus_mux_common
// Brief   : Shared AHB-Lite encodings for the N-master bus multiplexer.
// Rev     : 1.0
// ============================================================================
package ahbl_bus_mux_common;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Only NONSEQ/SEQ carry a real transfer; IDLE and BUSY are never captured.
    function automatic logic is_xfer(input logic [1:0] t);
        return (htrans_t'(t) == NONSEQ) || (htrans_t'(t) == SEQ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahbl_bus_mux_nm_arbiter.sv
`default_nettype none
// ============================================================================
// Module : ahbl_mux_arbiter
// Brief  : One-hot grant over pending requests, fixed priority or round-robin.
// Rev    : 1.0
// ============================================================================
module ahbl_mux_arbiter
    import ahbl_bus_mux_common::*;
#(
    parameter int N    = 2,
    parameter int MODE = 0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    generate
        if (MODE == int'(ARB_RR)) begin : g_rr
            logic [IW-1:0] rr_last_q;
            logic [IW-1:0] rr_last_d;
            logic [IW-1:0] idx;
            logic          found;

            // Search begins one past the last winner; pointer moves only on issue.
            always_comb begin
                grant     = '0;
                rr_last_d = rr_last_q;
                idx       = '0;
                found     = 1'b0;
                for (int k = 0; k < N; k++) begin
                    idx = IW'((int'(rr_last_q) + 1 + k) % N);
                    if (!found && req[idx]) begin
                        grant[idx] = 1'b1;
                        found      = 1'b1;
                        if (advance) begin
                            rr_last_d = idx;
                        end
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    rr_last_q <= IW'(N - 1);
                end else begin
                    rr_last_q <= rr_last_d;
                end
            end
        end else begin : g_fixed
            logic found;
            logic unused_fixed;

            assign unused_fixed = ^{clk_i, rst_ni, advance};

            always_comb begin
                grant = '0;
                found = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (!found && req[i]) begin
                        grant[i] = 1'b1;
                        found    = 1'b1;
                    end
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/ahbl_bus_mux_nm.sv
`default_nettype none
// ============================================================================
// Module : ahbl_bus_mux_nm
// Brief  : N-master to 1-slave AHB-Lite multiplexer with per-master pending slots.
// Rev    : 1.0
// ============================================================================
module ahbl_bus_mux_nm
    import ahbl_bus_mux_common::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ARB_MODE    = 0
) (
    input  logic                              HCLK,
    input  logic                              HRESETn,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_HADDR,
    input  logic [NUM_MASTERS*2-1:0]          m_HTRANS,
    input  logic [NUM_MASTERS-1:0]            m_HWRITE,
    input  logic [NUM_MASTERS*3-1:0]          m_HSIZE,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_HWDATA,
    output logic [DATA_WIDTH-1:0]             m_HRDATA,
    output logic [NUM_MASTERS-1:0]            m_HREADY,
    output logic [NUM_MASTERS-1:0]            m_HRESP,
    output logic [ADDR_WIDTH-1:0]             s_HADDR,
    output logic [1:0]                        s_HTRANS,
    output logic                              s_HWRITE,
    output logic [2:0]                        s_HSIZE,
    output logic [2:0]                        s_HBURST,
    output logic [DATA_WIDTH-1:0]             s_HWDATA,
    input  logic [DATA_WIDTH-1:0]             s_HRDATA,
    input  logic                              s_HREADY,
    input  logic                              s_HRESP
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0] pend_v_q;
    logic [NUM_MASTERS-1:0] pend_v_d;
    logic [ADDR_WIDTH-1:0]  pend_addr_q  [NUM_MASTERS];
    logic                   pend_write_q [NUM_MASTERS];
    logic [2:0]             pend_size_q  [NUM_MASTERS];
    logic                   dp_v_q;
    logic                   dp_v_d;
    logic [IW-1:0]          dp_owner_q;
    logic [IW-1:0]          dp_owner_d;

    logic [NUM_MASTERS-1:0] w_ready;
    logic [NUM_MASTERS-1:0] w_capture;
    logic [NUM_MASTERS-1:0] w_grant;
    logic                   w_issue;
    logic [IW-1:0]          w_win;

    generate
        for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_master
            logic w_own_dp;
            assign w_own_dp     = dp_v_q && (dp_owner_q == IW'(i));
            // A master stalls while its slot is full or its data phase is waited.
            assign w_ready[i]   = !pend_v_q[i] && !(w_own_dp && !s_HREADY);
            assign w_capture[i] = w_ready[i] && is_xfer(m_HTRANS[2*i +: 2]);
            assign m_HRESP[i]   = w_own_dp ? s_HRESP : HRESP_OKAY;
        end
    endgenerate

    assign m_HREADY = w_ready;
    assign m_HRDATA = s_HRDATA;
    assign s_HBURST = HBURST_SINGLE;
    assign w_issue  = s_HREADY && (|pend_v_q);

    ahbl_mux_arbiter #(
        .N    (NUM_MASTERS),
        .MODE (ARB_MODE)
    ) u_arbiter (
        .clk_i   (HCLK),
        .rst_ni  (HRESETn),
        .req     (pend_v_q),
        .advance (w_issue),
        .grant   (w_grant)
    );

    always_comb begin
        w_win = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_grant[i]) begin
                w_win = IW'(i);
            end
        end
    end

    // Capture never collides with issue for the same master: capture needs an empty slot.
    always_comb begin
        pend_v_d   = (pend_v_q & ~(w_grant & {NUM_MASTERS{w_issue}})) | w_capture;
        dp_v_d     = dp_v_q;
        dp_owner_d = dp_owner_q;
        if (s_HREADY) begin
            dp_v_d = w_issue;
            if (w_issue) begin
                dp_owner_d = w_win;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            pend_v_q   <= '0;
            dp_v_q     <= 1'b0;
            dp_owner_q <= '0;
        end else begin
            pend_v_q   <= pend_v_d;
            dp_v_q     <= dp_v_d;
            dp_owner_q <= dp_owner_d;
        end
    end

    always_ff @(posedge HCLK) begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_capture[i]) begin
                pend_addr_q[i]  <= m_HADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
                pend_write_q[i] <= m_HWRITE[i];
                pend_size_q[i]  <= m_HSIZE[i*3 +: 3];
            end
        end
    end

    // Address phase is only presented when it will be accepted, so it never changes mid-wait.
    always_comb begin
        s_HTRANS = IDLE;
        s_HADDR  = '0;
        s_HWRITE = 1'b0;
        s_HSIZE  = '0;
        if (w_issue) begin
            s_HTRANS = NONSEQ;
            s_HADDR  = pend_addr_q[w_win];
            s_HWRITE = pend_write_q[w_win];
            s_HSIZE  = pend_size_q[w_win];
        end
    end

    assign s_HWDATA = dp_v_q ? m_HWDATA[int'(dp_owner_q)*DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule
`default_nettype wire

// File: tb/tb_ahbl_bus_mux_nm.sv
`default_nettype none
// ============================================================================
// Module : tb_ahbl_bus_mux_nm
// Brief  : Fixed-priority and round-robin muxes driven side by side against a reference model.
// Rev    : 1.0
// ============================================================================
module tb_ahbl_bus_mux_nm;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic                HCLK;
    logic                hresetn;
    logic [NM*AW-1:0]    m_haddr;
    logic [NM*2-1:0]     m_htrans;
    logic [NM-1:0]       m_hwrite;
    logic [NM*3-1:0]     m_hsize;
    logic [NM*DW-1:0]    m_hwdata;
    logic [DW-1:0]       s_hrdata;
    logic                s_hready;
    logic                s_hresp;

    // Index 0: fixed-priority instance, index 1: round-robin instance.
    logic [DW-1:0]       m_hrdata_o [2];
    logic [NM-1:0]       m_hready_o [2];
    logic [NM-1:0]       m_hresp_o  [2];
    logic [AW-1:0]       s_haddr_o  [2];
    logic [1:0]          s_htrans_o [2];
    logic                s_hwrite_o [2];
    logic [2:0]          s_hsize_o  [2];
    logic [2:0]          s_hburst_o [2];
    logic [DW-1:0]       s_hwdata_o [2];

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    ahbl_bus_mux_nm #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(0)) dut_fixed (
        .HCLK(HCLK), .HRESETn(hresetn),
        .m_HADDR(m_haddr), .m_HTRANS(m_htrans), .m_HWRITE(m_hwrite), .m_HSIZE(m_hsize),
        .m_HWDATA(m_hwdata), .m_HRDATA(m_hrdata_o[0]), .m_HREADY(m_hready_o[0]), .m_HRESP(m_hresp_o[0]),
        .s_HADDR(s_haddr_o[0]), .s_HTRANS(s_htrans_o[0]), .s_HWRITE(s_hwrite_o[0]), .s_HSIZE(s_hsize_o[0]),
        .s_HBURST(s_hburst_o[0]), .s_HWDATA(s_hwdata_o[0]),
        .s_HRDATA(s_hrdata), .s_HREADY(s_hready), .s_HRESP(s_hresp)
    );

    ahbl_bus_mux_nm #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(1)) dut_rr (
        .HCLK(HCLK), .HRESETn(hresetn),
        .m_HADDR(m_haddr), .m_HTRANS(m_htrans), .m_HWRITE(m_hwrite), .m_HSIZE(m_hsize),
        .m_HWDATA(m_hwdata), .m_HRDATA(m_hrdata_o[1]), .m_HREADY(m_hready_o[1]), .m_HRESP(m_hresp_o[1]),
        .s_HADDR(s_haddr_o[1]), .s_HTRANS(s_htrans_o[1]), .s_HWRITE(s_hwrite_o[1]), .s_HSIZE(s_hsize_o[1]),
        .s_HBURST(s_hburst_o[1]), .s_HWDATA(s_hwdata_o[1]),
        .s_HRDATA(s_hrdata), .s_HREADY(s_hready), .s_HRESP(s_hresp)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Reference model: a slot per master, the transfer in data phase, and the last RR winner.
    bit            mpv [2][NM];
    logic [AW-1:0] mpa [2][NM];
    logic          mpw [2][NM];
    logic [2:0]    mps [2][NM];
    bit            mdv [2];
    int            mdo [2];
    int            mrr [2];

    function automatic int pick(input int k);
        for (int j = 0; j < NM; j++) begin
            int i;
            i = (k == 0) ? j : (mrr[k] + 1 + j) % NM;
            if (mpv[k][i]) return i;
        end
        return -1;
    endfunction

    function automatic bit mready(input int k, input int i);
        return !mpv[k][i] && !(mdv[k] && (mdo[k] == i) && !s_hready);
    endfunction

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        int          w;
        logic [NM-1:0] cap;
        logic [1:0]  ht;
        w = pick(k);
        for (int i = 0; i < NM; i++) begin
            ht     = m_htrans[2*i +: 2];
            cap[i] = mready(k, i) && (ht == 2'b10 || ht == 2'b11);
        end
        if (!hresetn) begin
            for (int i = 0; i < NM; i++) mpv[k][i] = 1'b0;
            mdv[k] = 1'b0;
            mrr[k] = NM - 1;
            return;
        end
        if (s_hready) begin
            if (w >= 0) begin
                mpv[k][w] = 1'b0;
                mdv[k]    = 1'b1;
                mdo[k]    = w;
                mrr[k]    = w;
            end else begin
                mdv[k] = 1'b0;
            end
        end
        for (int i = 0; i < NM; i++) begin
            if (cap[i]) begin
                mpv[k][i] = 1'b1;
                mpa[k][i] = m_haddr[i*AW +: AW];
                mpw[k][i] = m_hwrite[i];
                mps[k][i] = m_hsize[3*i +: 3];
            end
        end
    endtask

    task automatic check_outputs(input int k);
        int            w;
        logic          iss;
        logic [NM-1:0] er;
        logic [NM-1:0] eh;
        logic [AW-1:0] ea;
        logic          ew;
        logic [2:0]    es;
        logic [DW-1:0] ed;
        w   = pick(k);
        iss = s_hready && (w >= 0);
        for (int i = 0; i < NM; i++) begin
            er[i] = mready(k, i);
            eh[i] = (mdv[k] && mdo[k] == i) ? s_hresp : 1'b0;
        end
        ea = '0; ew = 1'b0; es = '0;
        if (iss) begin
            ea = mpa[k][w]; ew = mpw[k][w]; es = mps[k][w];
        end
        ed = mdv[k] ? m_hwdata[mdo[k]*DW +: DW] : '0;
        chk("m_HREADY", k, 64'(m_hready_o[k]), 64'(er));
        chk("m_HRESP",  k, 64'(m_hresp_o[k]),  64'(eh));
        chk("m_HRDATA", k, 64'(m_hrdata_o[k]), 64'(s_hrdata));
        chk("s_HTRANS", k, 64'(s_htrans_o[k]), iss ? 64'd2 : 64'd0);
        chk("s_HADDR",  k, 64'(s_haddr_o[k]),  64'(ea));
        chk("s_HWRITE", k, 64'(s_hwrite_o[k]), 64'(ew));
        chk("s_HSIZE",  k, 64'(s_hsize_o[k]),  64'(es));
        chk("s_HBURST", k, 64'(s_hburst_o[k]), 64'd0);
        chk("s_HWDATA", k, 64'(s_hwdata_o[k]), 64'(ed));
    endtask

    always @(posedge HCLK) begin
        for (int k = 0; k < 2; k++) model_step(k);
    end

    always @(negedge HCLK) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) check_outputs(k);
        end
    end

    task automatic set_m(input int i, input logic [1:0] t, input logic [AW-1:0] a,
                         input logic wr, input logic [2:0] sz);
        m_htrans[2*i +: 2] = t;
        m_haddr[i*AW +: AW] = a;
        m_hwrite[i]         = wr;
        m_hsize[3*i +: 3]   = sz;
    endtask

    task automatic idle_all();
        for (int i = 0; i < NM; i++) set_m(i, 2'b00, '0, 1'b0, 3'd0);
    endtask

    task automatic nxt();
        @(posedge HCLK);
        #1;
    endtask

    task automatic smp();
        @(negedge HCLK);
    endtask

    logic [AW-1:0] rr_exp [4];

    initial begin
        hresetn  = 1'b0;
        m_hwdata = '0;
        s_hrdata = '0;
        s_hready = 1'b1;
        s_hresp  = 1'b0;
        rr_exp[0] = 32'h100; rr_exp[1] = 32'h200; rr_exp[2] = 32'h100; rr_exp[3] = 32'h200;

        // Reset held two cycles with both masters requesting
        set_m(0, 2'b10, 32'h40, 1'b0, 3'd2);
        set_m(1, 2'b10, 32'h80, 1'b0, 3'd2);
        nxt(); chk_en = 1'b1; smp();
        chk("rst_htrans", 0, 64'(s_htrans_o[0]), 64'd0);
        chk("rst_hready", 1, 64'(m_hready_o[1]), 64'h3);
        nxt(); smp();
        chk("rst_hready", 0, 64'(m_hready_o[0]), 64'h3);
        nxt(); hresetn = 1'b1; idle_all(); smp();
        chk("post_rst_htrans", 0, 64'(s_htrans_o[0]), 64'd0);
        chk("post_rst_hready", 0, 64'(m_hready_o[0]), 64'h3);
        chk("post_rst_haddr",  1, 64'(s_haddr_o[1]),  64'd0);

        // Single write, zero-wait slave
        nxt(); set_m(0, 2'b10, 32'h1000, 1'b1, 3'd2); smp();
        chk("wr_a_hready", 0, 64'(m_hready_o[0]), 64'h3);
        nxt(); idle_all(); m_hwdata[0 +: DW] = 32'hDEADBEEF; smp();
        chk("wr_b_htrans", 0, 64'(s_htrans_o[0]), 64'd2);
        chk("wr_b_haddr",  0, 64'(s_haddr_o[0]),  64'h1000);
        chk("wr_b_hwrite", 0, 64'(s_hwrite_o[0]), 64'd1);
        chk("wr_b_hready", 0, 64'(m_hready_o[0]), 64'h2);
        nxt(); smp();
        chk("wr_c_hwdata", 0, 64'(s_hwdata_o[0]), 64'hDEADBEEF);
        chk("wr_c_hready", 0, 64'(m_hready_o[0]), 64'h3);

        // Contention: fixed picks m0 first, round-robin (last winner m0) picks m1 first
        nxt(); set_m(0, 2'b10, 32'h10, 1'b0, 3'd2); set_m(1, 2'b10, 32'h20, 1'b0, 3'd2); smp();
        nxt(); idle_all(); smp();
        chk("ct_b_haddr",  0, 64'(s_haddr_o[0]),  64'h10);
        chk("ct_b_hready", 0, 64'(m_hready_o[0]), 64'h0);
        chk("ct_b_haddr",  1, 64'(s_haddr_o[1]),  64'h20);
        nxt(); smp();
        chk("ct_c_haddr",  0, 64'(s_haddr_o[0]),  64'h20);
        chk("ct_c_hready", 0, 64'(m_hready_o[0]), 64'h1);
        chk("ct_c_haddr",  1, 64'(s_haddr_o[1]),  64'h10);
        chk("ct_c_hready", 1, 64'(m_hready_o[1]), 64'h2);
        nxt(); smp();
        chk("ct_d_hready", 0, 64'(m_hready_o[0]), 64'h3);
        chk("ct_d_htrans", 0, 64'(s_htrans_o[0]), 64'd0);

        // Round-robin from reset with both masters streaming: 0,1,0,1
        nxt(); hresetn = 1'b0; smp();
        nxt(); hresetn = 1'b1;
        set_m(0, 2'b10, 32'h100, 1'b0, 3'd2); set_m(1, 2'b10, 32'h200, 1'b0, 3'd2); smp();
        for (int j = 0; j < 4; j++) begin
            nxt(); smp();
            chk("rr_htrans", 1, 64'(s_htrans_o[1]), 64'd2);
            chk("rr_order",  1, 64'(s_haddr_o[1]),  64'(rr_exp[j]));
        end
        nxt(); idle_all();
        repeat (3) nxt();

        // Two wait states then a two-cycle ERROR on m1; m0 stays pending
        nxt(); hresetn = 1'b0; smp();
        nxt(); hresetn = 1'b1; set_m(1, 2'b10, 32'h300, 1'b0, 3'd2); smp();
        nxt(); idle_all(); set_m(0, 2'b10, 32'h400, 1'b1, 3'd2); smp();
        chk("er_issue_haddr", 0, 64'(s_haddr_o[0]),  64'h300);
        chk("er_issue_hready", 0, 64'(m_hready_o[0]), 64'h1);
        nxt(); idle_all(); s_hready = 1'b0; smp();
        chk("er_w1_hready", 0, 64'(m_hready_o[0]), 64'h0);
        chk("er_w1_htrans", 0, 64'(s_htrans_o[0]), 64'd0);
        nxt(); smp();
        chk("er_w2_hresp", 0, 64'(m_hresp_o[0]), 64'h0);
        nxt(); s_hresp = 1'b1; smp();
        chk("er_e1_hresp",  0, 64'(m_hresp_o[0]),  64'h2);
        chk("er_e1_hready", 0, 64'(m_hready_o[0]), 64'h0);
        nxt(); s_hready = 1'b1; smp();
        chk("er_e2_hresp",  0, 64'(m_hresp_o[0]),  64'h2);
        chk("er_e2_hready", 0, 64'(m_hready_o[0]), 64'h2);
        chk("er_e2_haddr",  0, 64'(s_haddr_o[0]),  64'h400);
        chk("er_e2_htrans", 1, 64'(s_htrans_o[1]), 64'd2);
        nxt(); s_hresp = 1'b0; smp();
        chk("er_done_hready", 0, 64'(m_hready_o[0]), 64'h3);
        chk("er_done_hresp",  0, 64'(m_hresp_o[0]),  64'h0);

        // Reset with m0 pending and m1 in data phase
        nxt(); set_m(1, 2'b10, 32'h500, 1'b0, 3'd2); smp();
        nxt(); idle_all(); set_m(0, 2'b10, 32'h600, 1'b0, 3'd2); smp();
        nxt(); idle_all(); hresetn = 1'b0; smp();
        chk("mr_pre_hready", 0, 64'(m_hready_o[0]), 64'h2);
        nxt(); hresetn = 1'b1; smp();
        chk("mr_htrans", 0, 64'(s_htrans_o[0]), 64'd0);
        chk("mr_htrans", 1, 64'(s_htrans_o[1]), 64'd0);
        chk("mr_hready", 0, 64'(m_hready_o[0]), 64'h3);
        chk("mr_hready", 1, 64'(m_hready_o[1]), 64'h3);
        chk("mr_hwdata", 0, 64'(s_hwdata_o[0]), 64'd0);

        // Randomized traffic with occasional resets, checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            nxt();
            hresetn = ($urandom_range(0, 99) != 0);
            for (int i = 0; i < NM; i++) begin
                set_m(i, 2'($urandom_range(0, 3)), AW'($urandom()), 1'($urandom_range(0, 1)),
                      3'($urandom_range(0, 2)));
                m_hwdata[i*DW +: DW] = DW'($urandom());
            end
            s_hready = ($urandom_range(0, 3) != 0);
            s_hresp  = ($urandom_range(0, 7) == 0);
            s_hrdata = DW'($urandom());
        end
        nxt(); smp();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
